dff_monitor: RTL and testbench

DFF_MONITOR -- requirements
Module: dff_monitor

---
 rtl/dff_monitor.sv | 147 ++++++++++++++
 tb/tb_dff_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dff_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : dff_monitor
//  Purpose  : Watches the d/en/rst/q pins of an enable flop with synchronous
//             reset, predicts q from its own model and counts matching and
//             mismatching cycles over a run of num_checks comparisons.
//  Revision : 1.0  initial release
// ============================================================================
module dff_monitor #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             mon_d,
  input  logic             mon_en,
  input  logic             mon_rst,
  input  logic             mon_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] correct_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_cycle
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_target;      // num_checks latched at start
  logic [CNT_W-1:0] r_checked;     // comparisons performed this run
  logic [CNT_W-1:0] r_cycle;       // RUN-edge index, saturating
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_cor_cnt;
  logic             r_fev;
  logic [CNT_W-1:0] r_fec;
  logic             r_model_valid; // exp_q is trustworthy once rst/en seen
  logic             r_exp_q;       // predicted q of the monitored flop

  logic             w_accept;
  logic             w_cmp;
  logic             w_last;

  // Start is honoured outside RUN; a comparison finishing the run ends it.
  always_comb begin
    w_accept    = start && (r_state != S_RUN);
    w_cmp       = (r_state == S_RUN) && r_model_valid;
    w_last      = w_cmp && ((r_checked + c_ONE) == r_target);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = (num_checks == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run bookkeeping, flop model and comparison counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target      <= '0;
      r_checked     <= '0;
      r_cycle       <= '0;
      r_err_cnt     <= '0;
      r_cor_cnt     <= '0;
      r_fev         <= 1'b0;
      r_fec         <= '0;
      r_model_valid <= 1'b0;
      r_exp_q       <= RESET_VAL;
    end else if (w_accept) begin
      r_target      <= num_checks;
      r_checked     <= '0;
      r_cycle       <= '0;
      r_err_cnt     <= '0;
      r_cor_cnt     <= '0;
      r_fev         <= 1'b0;
      r_fec         <= '0;
      r_model_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (r_cycle != '1) begin
        r_cycle <= r_cycle + c_ONE;
      end
      // Reset of the monitored flop wins over its enable.
      if (mon_rst) begin
        r_exp_q <= RESET_VAL;
      end else if (mon_en) begin
        r_exp_q <= mon_d;
      end
      if (mon_rst || mon_en) begin
        r_model_valid <= 1'b1;
      end
      // Both mon_q and r_exp_q reflect the previous edge here.
      if (w_cmp) begin
        r_checked <= r_checked + c_ONE;
        if (mon_q == r_exp_q) begin
          r_cor_cnt <= r_cor_cnt + c_ONE;
        end else begin
          r_err_cnt <= r_err_cnt + c_ONE;
          if (!r_fev) begin
            r_fev <= 1'b1;
            r_fec <= r_cycle;
          end
        end
      end
    end
  end

  // Status outputs are decoded from registered state only.
  always_comb begin
    busy            = (r_state == S_RUN);
    done            = (r_state == S_DONE);
    pass            = (r_state == S_DONE) && (r_err_cnt == '0);
    error_count     = r_err_cnt;
    correct_count   = r_cor_cnt;
    first_err_valid = r_fev;
    first_err_cycle = r_fec;
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_monitor
//  Purpose  : Directed self-checking bench for dff_monitor; a behavioural
//             enable flop drives mon_q, expected outputs go through a queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_monitor;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_checks;
  logic             mon_d;
  logic             mon_en;
  logic             mon_rst;
  logic             mon_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] correct_count;
  logic             first_err_valid;
  logic [CNT_W-1:0] first_err_cycle;

  logic             flop_q;
  logic             stuck;

  typedef struct {
    string      tag;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [7:0] cor;
    logic       fev;
    logic [7:0] fec;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  dff_monitor #(
    .RESET_VAL (1'b0),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_checks      (num_checks),
    .mon_d           (mon_d),
    .mon_en          (mon_en),
    .mon_rst         (mon_rst),
    .mon_q           (mon_q),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (error_count),
    .correct_count   (correct_count),
    .first_err_valid (first_err_valid),
    .first_err_cycle (first_err_cycle)
  );

  always #5 clk = ~clk;

  // Reference enable flop with synchronous reset (reset value 0).
  always @(posedge clk) begin
    if (mon_rst) flop_q <= 1'b0;
    else if (mon_en) flop_q <= mon_d;
  end

  assign mon_q = stuck ? 1'b1 : flop_q;

  task automatic chk(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s: observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue the outputs expected after the edge,
  // then pop and compare once the edge has happened.
  task automatic cyc(input logic s, input logic [7:0] n, input logic r,
                     input logic en, input logic d, input string tag,
                     input logic b, input logic dn, input logic p,
                     input logic [7:0] e, input logic [7:0] c,
                     input logic v, input logic [7:0] f);
    exp_t x;
    exp_t y;
    start      = s;
    num_checks = n;
    mon_rst    = r;
    mon_en     = en;
    mon_d      = d;
    x.tag = tag; x.busy = b; x.done = dn; x.pass = p;
    x.err = e;   x.cor = c;  x.fev = v;   x.fec = f;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.queue: observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      y = sb.pop_front();
      chk(y.tag, "busy",            {7'd0, busy},            {7'd0, y.busy});
      chk(y.tag, "done",            {7'd0, done},            {7'd0, y.done});
      chk(y.tag, "pass",            {7'd0, pass},            {7'd0, y.pass});
      chk(y.tag, "error_count",     error_count,             y.err);
      chk(y.tag, "correct_count",   correct_count,           y.cor);
      chk(y.tag, "first_err_valid", {7'd0, first_err_valid}, {7'd0, y.fev});
      chk(y.tag, "first_err_cycle", first_err_cycle,         y.fec);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_checks = '0;
    mon_d = 1'b0; mon_en = 1'b0; mon_rst = 1'b0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, "reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Correct flop, four comparisons.
    cyc(1, 4, 0, 0, 0, "A_start", 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4, 1, 0, 0, "A_c0",    1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4, 0, 1, 1, "A_c1",    1, 0, 0, 0, 1, 0, 0);
    cyc(0, 4, 0, 0, 0, "A_c2",    1, 0, 0, 0, 2, 0, 0);
    cyc(0, 4, 0, 0, 1, "A_c3",    1, 0, 0, 0, 3, 0, 0);
    cyc(0, 4, 0, 1, 0, "A_c4",    0, 1, 1, 0, 4, 0, 0);
    cyc(0, 4, 1, 1, 1, "A_hold",  0, 1, 1, 0, 4, 0, 0);

    // q stuck at 1; restart from DONE clears the previous counts.
    stuck = 1'b1;
    cyc(1, 3, 0, 0, 0, "B_start", 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 3, 1, 0, 0, "B_c0",    1, 0, 0, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, "B_c1",    1, 0, 0, 1, 0, 1, 1);
    cyc(0, 3, 0, 0, 0, "B_c2",    1, 0, 0, 2, 0, 1, 1);
    cyc(0, 3, 0, 0, 0, "B_c3",    0, 1, 0, 3, 0, 1, 1);
    stuck = 1'b0;

    // Model not valid for five RUN cycles; start during RUN is ignored.
    cyc(1, 2, 0, 0, 0, "C_start", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2) ? 1'b1 : 1'b0, 0, 0, 0, 0, $sformatf("C_idle%0d", i),
          1, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 1, "C_en",   1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, "C_cmp1", 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, "C_cmp2", 0, 1, 1, 0, 2, 0, 0);

    // Zero-length run goes straight to DONE.
    cyc(1, 0, 0, 0, 0, "D_start", 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, "D_hold",  0, 1, 1, 0, 0, 0, 0);

    // Reset mid-run after two comparisons, then a fresh run.
    cyc(1, 5, 0, 0, 0, "E_start", 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 1, 0, 0, "E_c0",    1, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 0, 1, 0, "E_c1",    1, 0, 0, 0, 1, 0, 0);
    cyc(0, 5, 0, 1, 1, "E_c2",    1, 0, 0, 0, 2, 0, 0);
    rst = 1'b1;
    cyc(1, 5, 0, 1, 1, "E_rst",   0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 1, 0, 0, 0, "E_restart", 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, "E_r0",      1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, "E_r1",      0, 1, 1, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
